genit_bank: RTL and testbench

Parametrised multi-channel sampling bank: NUM_CH independent lanes built in a `for (genvar ...)` generate loop. Each lane delays its input bit by a configurable pipeline and counts rising edges. A round-robin readout FSM drains the non-zero lane counters over a valid/ready handshake. It is the generalised successor of the single-instance generate wrapper: it adds width, depth and per-lane state, plus a hierarchical debug tap that benches read directly.

---
 rtl/genit_pkg.sv | 10 +
 rtl/genit_lane.sv | 44 ++++
 rtl/genit_bank.sv | 69 ++++++
 tb/tb_genit_bank.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/genit_pkg.sv
// genit_pkg: shared types, defaults and width helper for the genit sampling bank.
package genit_pkg;
  typedef enum logic {SCAN, PRESENT} state_e;
  localparam int NUM_CH_DEF = 4;
  localparam int DELAY_DEF = 2;
  localparam int CNT_W_DEF = 8;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/genit_lane.sv
// genit_lane: one lane - DELAY-stage pipeline plus saturating rising-edge counter with clear.
module genit_lane import genit_pkg::*; #(
  parameter int DELAY = DELAY_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr,
  output logic             dout,
  output logic [CNT_W-1:0] count
);
  logic             internal;
  logic             edge_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      internal <= 1'b0;
      edge_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      internal <= din;
      edge_q   <= internal;
      cnt_q    <= cnt_d;
    end
  end
  assign rise = internal & ~edge_q;
  // a rise coinciding with a readout clear restarts the count at 1 so it is not lost
  always_comb cnt_d = clr ? CNT_W'(rise) : (rise && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign count = cnt_q;
  if (DELAY > 1) begin : g_pipe
    logic [DELAY-1:1] pipe_q;
    logic [DELAY-1:0] chain;
    assign chain = {pipe_q, internal};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) pipe_q <= '0;
      else pipe_q <= chain[DELAY-2:0];
    end
    assign dout = pipe_q[DELAY-1];
  end else begin : g_nopipe
    assign dout = internal;
  end
endmodule

// File: rtl/genit_bank.sv
// genit_bank: NUM_CH sampling lanes drained round-robin over a valid/ready readout port.
module genit_bank import genit_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DELAY = DELAY_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int CH_W = clog2_min1(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] value,
  output logic [NUM_CH-1:0] result,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [CH_W-1:0]   rd_ch,
  output logic [CNT_W-1:0]  rd_count
);
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] clr;
  state_e            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d, ptr_nx, rd_ch_q, rd_ch_d;
  logic [CNT_W-1:0]  rd_count_q, rd_count_d, cur;
  logic              grab;
  for (genvar i = 0; i < NUM_CH; i++) begin : lane
    genit_lane #(.DELAY(DELAY), .CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .din   (value[i]),
      .clr   (clr[i]),
      .dout  (result[i]),
      .count (cnt[i])
    );
    assign clr[i] = grab && (ptr_q == CH_W'(i));
  end
  assign cur    = cnt[ptr_q];
  assign grab   = (state_q == SCAN) && (cur != '0);
  assign ptr_nx = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + CH_W'(1);
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_ch_d    = rd_ch_q;
    rd_count_d = rd_count_q;
    if (grab) begin
      state_d    = PRESENT;
      rd_ch_d    = ptr_q;
      rd_count_d = cur;
    end else if (state_q == SCAN) begin
      ptr_d = ptr_nx;
    end else if (rd_ready) begin
      state_d = SCAN;
      ptr_d   = ptr_nx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      ptr_q      <= '0;
      rd_ch_q    <= '0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_ch_q    <= rd_ch_d;
      rd_count_q <= rd_count_d;
    end
  end
  assign rd_valid = (state_q == PRESENT);
  assign rd_ch    = rd_ch_q;
  assign rd_count = rd_count_q;
endmodule

// File: tb/tb_genit_bank.sv
// tb_genit_bank: directed checks of the genit bank (main instance plus a CNT_W=2 saturation instance).
module tb_genit_bank;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] value, value_s;
  logic       rd_ready, ready_s;
  wire  [3:0] result, result_s;
  wire        rd_valid, valid_s;
  wire  [1:0] rd_ch, ch_s;
  wire  [7:0] rd_count;
  wire  [1:0] count_s;
  int total = 0;
  int bad = 0;
  bit ok;
  always #5 clk = ~clk;
  genit_bank #(.NUM_CH(4), .DELAY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .value(value), .result(result),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ch(rd_ch), .rd_count(rd_count)
  );
  genit_bank #(.NUM_CH(4), .DELAY(2), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .value(value_s), .result(result_s),
    .rd_valid(valid_s), .rd_ready(ready_s), .rd_ch(ch_s), .rd_count(count_s)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input bit sat, input int n, output bit found);
    found = 1'b0;
    for (int i = 0; i < n && !found; i++) begin
      if (sat ? valid_s : rd_valid) found = 1'b1;
      else tick();
    end
  endtask
  task automatic pulse(input int ln);
    value[ln] = 1'b1;
    tick();
    value[ln] = 1'b0;
    tick();
  endtask
  task automatic pulse_s(input int ln);
    value_s[ln] = 1'b1;
    tick();
    value_s[ln] = 1'b0;
    tick();
  endtask
  initial begin
    rst = 1'b1; value = 4'hF; value_s = 4'h0; rd_ready = 1'b0; ready_s = 1'b0;
    repeat (3) tick();
    check("rst_result", result, 4'h0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_ch", rd_ch, 2'd0);
    check("rst_count", rd_count, 8'd0);
    rst = 1'b0;
    tick();
    check("tap_lane2", dut.lane[2].u_lane.internal, 1'b1);
    check("result_1edge", result, 4'h0);
    tick();
    check("result_delay", result, 4'hF);
    value = 4'h0; rd_ready = 1'b1;
    repeat (20) tick();
    check("drained", rd_valid, 1'b0);
    rd_ready = 1'b0;
    pulse(0);
    wait_valid(0, 20, ok);
    check("park_seen", ok, 1'b1);
    check("park_word", {rd_ch, rd_count}, {2'd0, 8'd1});
    for (int i = 0; i < 5; i++) pulse(1);
    repeat (2) tick();
    check("park_held", {rd_valid, rd_ch, rd_count}, {1'b1, 2'd0, 8'd1});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    wait_valid(0, 10, ok);
    check("edges_seen", ok, 1'b1);
    check("edges_word", {rd_ch, rd_count}, {2'd1, 8'd5});
    for (int i = 0; i < 10; i++) begin
      tick();
      check("edges_hold", {rd_valid, rd_ch, rd_count}, {1'b1, 2'd1, 8'd5});
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("edges_accept", rd_valid, 1'b0);
    pulse_s(1);
    wait_valid(1, 20, ok);
    check("sat_park_seen", ok, 1'b1);
    check("sat_park_word", {ch_s, count_s}, {2'd1, 2'd1});
    for (int i = 0; i < 7; i++) pulse_s(0);
    repeat (2) tick();
    ready_s = 1'b1;
    tick();
    ready_s = 1'b0;
    wait_valid(1, 10, ok);
    check("sat_seen", ok, 1'b1);
    check("sat_word", {ch_s, count_s}, {2'd0, 2'd3});
    ready_s = 1'b1;
    tick();
    ready_s = 1'b0;
    pulse(2);
    wait_valid(0, 20, ok);
    check("coin_park_seen", ok, 1'b1);
    check("coin_park_word", {rd_ch, rd_count}, {2'd2, 8'd1});
    pulse(3);
    repeat (2) tick();
    rd_ready = 1'b1; value[3] = 1'b1;
    tick();
    rd_ready = 1'b0; value[3] = 1'b0;
    tick();
    check("coin_first", {rd_valid, rd_ch, rd_count}, {1'b1, 2'd3, 8'd1});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    wait_valid(0, 10, ok);
    check("coin_second_seen", ok, 1'b1);
    check("coin_second", {rd_ch, rd_count}, {2'd3, 8'd1});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    pulse(1);
    wait_valid(0, 20, ok);
    check("ar_park_seen", ok, 1'b1);
    pulse(0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("ar_valid_async", rd_valid, 1'b0);
    check("ar_word_async", {rd_ch, rd_count}, {2'd0, 8'd0});
    rd_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("ar_post1", rd_valid, 1'b0);
    tick();
    check("ar_post2", rd_valid, 1'b0);
    value = 4'hF;
    tick();
    value = 4'h0;
    check("ar_post3", rd_valid, 1'b0);
    tick();
    check("ar_post4", rd_valid, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("rr_word%0d", j), {rd_valid, rd_ch, rd_count}, {1'b1, 2'(j), 8'd1});
      tick();
      check($sformatf("rr_gap%0d", j), rd_valid, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
